sap1_controller: RTL
====================

# sap1_controller

Control sequencer for the SAP-1 datapath. It is the initiator side of the bus-strobe interface that the accumulator, B register, MAR, RAM, instruction register, ALU, output register and program counter respond to. The controller steps a six-state T-cycle ring (three fetch states, then three execute states), decodes the instruction register opcode, and drives one load or enable strobe per datapath register each cycle. Registers sample their strobes on the next `i_clk` rising edge.

## Interface
- `OpWidth`, default 4: opcode width taken from the instruction register high nibble.
- `i_clk`  input  1  system clock; all state changes occur on the rising edge.
- `i_rst_n`  input  1  reset, asynchronous and active-low.
- `i_en`  input  1  run enable; when low, state holds (single-step and stall).
- `i_opcode`  input  OpWidth  current instruction register opcode.
- `o_cp`  output  1  PC increment.
- `o_ep`  output  1  PC drives bus.
- `o_lm`  output  1  MAR load.
- `o_ce`  output  1  RAM drives bus.
- `o_li`  output  1  IR load.
- `o_ei`  output  1  IR operand nibble drives bus.
- `o_la`  output  1  accumulator load.
- `o_ea`  output  1  accumulator drives bus.
- `o_su`  output  1  ALU subtract select.
- `o_eu`  output  1  ALU drives bus.
- `o_lb`  output  1  B register load.
- `o_lo`  output  1  output register load.
- `o_hlt`  output  1  halted; clock gating and status.
- `o_tstate`  output  6  one-hot T-state, with bit0 = T1 (debug); all zero in RST and HALT.

## Operation
- States: RST, T1 to T6, HALT.
- Control outputs are a combinational decode of state and `i_opcode`. They are valid for the whole state cycle.
- Opcodes: LDA=0000, ADD=0001, SUB=0010, OUT=1110, HLT=1111. All other opcodes are NOPs: they get fetch strobes only, and T4 to T6 are idle.
- RST: all strobes 0, `o_hlt`=0.
- Fetch, same for every opcode:
  - T1: `o_ep`, `o_lm`.
  - T2: `o_cp`.
  - T3: `o_ce`, `o_li`.
- Execute:
  - LDA: T4 `o_ei`, `o_lm`; T5 `o_ce`, `o_la`; T6 none.
  - ADD: T4 `o_ei`, `o_lm`; T5 `o_ce`, `o_lb`; T6 `o_eu`, `o_la`.
  - SUB: same as ADD, and `o_su` is asserted in T6.
  - OUT: T4 `o_ea`, `o_lo`; T5 and T6 none.
  - HLT: T4 has no strobes; the next state is HALT.
- At most one bus driver among `o_ep`, `o_ce`, `o_ei`, `o_ea`, `o_eu` is asserted in any state. This is an invariant, and it is asserted in simulation.
- `i_opcode` is sampled only during T4 to T6. Its value during T1 to T3 is ignored.

## Timing
- Async reset: state goes to RST immediately. All strobes go to 0 and `o_hlt` goes to 0 within the same cycle, without waiting for a clock edge.
- First rising edge after reset release with `i_en`=1: RST to T1.
- Each rising edge with `i_en`=1: Tn to Tn+1, T6 to T1, and T4 to HALT when the opcode is HLT.
- `i_en`=0: state holds and strobes stay at their current decode. Datapath blocks must therefore also be gated by `i_en`. The controller does not mask strobes.
- Instruction latency: exactly 6 enabled cycles. HLT takes 4 enabled cycles to reach HALT.
- HALT: all strobes 0 and `o_hlt`=1. The block stays in HALT until `i_rst_n` goes low, regardless of `i_en`.
- Reset asserted mid-instruction aborts the instruction. No strobe from the aborted T-state survives the reset assertion.
- Opcode changing during T4 to T6 is illegal; the decode follows the current value.

## Structure
- Shared package `sap1_pkg`:
  - opcode constants;
  - state encoding;
  - control-word bit indices (one 12-bit control word, unpacked to ports at the top).
- Sub-module `sap1_ring_counter`: one-hot T1 to T6 counter with async active-low reset, enable, and a synchronous halt input. The controller adds the RST/HALT wrapper and the decode.

## Test plan
- Reset, then `i_en`=1 held: in cycle 1 all strobes are 0; cycle 2 is T1 with `o_ep`=`o_lm`=1 and `o_tstate`=000001; cycle 3 is T2 with only `o_cp`.
- Opcode 0000 (LDA): T4 `o_ei`+`o_lm`, T5 `o_ce`+`o_la`, T6 all 0, then back to T1 with `o_tstate`=000001.
- Opcode 0010 (SUB): T6 asserts `o_eu`, `o_la`, `o_su` together. The same run with 0001 (ADD) has `o_su`=0 in T6.
- Opcode 1110 (OUT): T4 `o_ea`+`o_lo`. Opcode 0101: T4 to T6 all 0, with normal fetch afterwards.
- Opcode 1111 (HLT): `o_hlt`=1 after the T4 edge. It stays high for 20 more cycles with strobes 0, and clears asynchronously when `i_rst_n` goes to 0.
- `i_en`=0 for 3 cycles in T5 of ADD: `o_ce`+`o_lb` are held and `o_tstate`=010000 is unchanged. Then `i_rst_n` low mid-T5: strobes go to 0 before the next edge, and the ring restarts at T1 after release.

Source files
------------

// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 control sequencer: opcodes, FSM states, control-word layout.
package sap1_pkg;

  // Instruction opcodes (instruction register high nibble).
  typedef enum logic [3:0] {
    OpLda = 4'b0000,
    OpAdd = 4'b0001,
    OpSub = 4'b0010,
    OpOut = 4'b1110,
    OpHlt = 4'b1111
  } opcode_e;

  // Outer wrapper around the T-state ring.
  typedef enum logic [1:0] {
    StRst,
    StRun,
    StHalt
  } state_e;

  localparam int unsigned NumTStates = 6;

  // Control-word bit indices; the word is unpacked onto individual strobes at the top.
  localparam int unsigned CtrlWidth = 12;
  localparam int unsigned CtrlCp    = 0;
  localparam int unsigned CtrlEp    = 1;
  localparam int unsigned CtrlLm    = 2;
  localparam int unsigned CtrlCe    = 3;
  localparam int unsigned CtrlLi    = 4;
  localparam int unsigned CtrlEi    = 5;
  localparam int unsigned CtrlLa    = 6;
  localparam int unsigned CtrlEa    = 7;
  localparam int unsigned CtrlSu    = 8;
  localparam int unsigned CtrlEu    = 9;
  localparam int unsigned CtrlLb    = 10;
  localparam int unsigned CtrlLo    = 11;

  typedef logic [CtrlWidth-1:0] ctrl_t;

endpackage

// File: rtl/sap1_controller_if.sv
// Strobe/status bundle between the SAP-1 controller (master) and the datapath (slave).
interface sap1_controller_if #(
  parameter int unsigned OpWidth = 4
) ();

  logic               i_en;
  logic [OpWidth-1:0] i_opcode;
  logic               o_cp;
  logic               o_ep;
  logic               o_lm;
  logic               o_ce;
  logic               o_li;
  logic               o_ei;
  logic               o_la;
  logic               o_ea;
  logic               o_su;
  logic               o_eu;
  logic               o_lb;
  logic               o_lo;
  logic               o_hlt;
  logic [5:0]         o_tstate;

  modport master (
    input  i_en, i_opcode,
    output o_cp, o_ep, o_lm, o_ce, o_li, o_ei, o_la, o_ea, o_su, o_eu, o_lb, o_lo,
    output o_hlt, o_tstate
  );

  modport slave (
    output i_en, i_opcode,
    input  o_cp, o_ep, o_lm, o_ce, o_li, o_ei, o_la, o_ea, o_su, o_eu, o_lb, o_lo,
    input  o_hlt, o_tstate
  );

endinterface

// File: rtl/sap1_ring_counter.sv
// One-hot T-state ring: load T1 on start, rotate when enabled, clear on halt.
module sap1_ring_counter #(
  parameter int unsigned Width = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             start_i,
  input  logic             halt_i,
  output logic [Width-1:0] tstate_o
);

  logic [Width-1:0] ring_d, ring_q;

  // Next ring value; an all-zero ring rotates to itself, so idle/halted stays idle.
  always_comb begin
    ring_d = ring_q;
    if (en_i) begin
      if (halt_i) begin
        ring_d = '0;
      end else if (start_i) begin
        ring_d = Width'(1);
      end else begin
        ring_d = {ring_q[Width-2:0], ring_q[Width-1]};
      end
    end
  end

  // Ring state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ring_q <= '0;
    end else begin
      ring_q <= ring_d;
    end
  end

  assign tstate_o = ring_q;

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: RST/RUN/HALT wrapper around the T-state ring plus strobe decode.
module sap1_controller
  import sap1_pkg::*;
#(
  parameter int unsigned OpWidth = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  sap1_controller_if.master   bus
);

  state_e                  state_d, state_q;
  logic [NumTStates-1:0]   tstate;
  logic                    start;
  logic                    halt;
  ctrl_t                   ctrl;
  logic                    is_lda, is_arith, is_sub, is_out, is_hlt;

  sap1_ring_counter #(
    .Width (NumTStates)
  ) u_ring (
    .clk_i    (i_clk),
    .rst_ni   (i_rst_n),
    .en_i     (bus.i_en),
    .start_i  (start),
    .halt_i   (halt),
    .tstate_o (tstate)
  );

  // Instruction class from the opcode; only consumed in T4..T6.
  always_comb begin
    is_lda   = (bus.i_opcode == OpWidth'(OpLda));
    is_sub   = (bus.i_opcode == OpWidth'(OpSub));
    is_arith = (bus.i_opcode == OpWidth'(OpAdd)) || is_sub;
    is_out   = (bus.i_opcode == OpWidth'(OpOut));
    is_hlt   = (bus.i_opcode == OpWidth'(OpHlt));
  end

  // Wrapper next state and ring control; HALT is only left through reset.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    halt    = 1'b0;
    unique case (state_q)
      StRst: begin
        if (bus.i_en) begin
          state_d = StRun;
          start   = 1'b1;
        end
      end
      StRun: begin
        if (bus.i_en && tstate[3] && is_hlt) begin
          state_d = StHalt;
          halt    = 1'b1;
        end
      end
      StHalt: begin
        halt = 1'b1;
      end
      default: begin
        state_d = StRst;
      end
    endcase
  end

  // Wrapper state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StRst;
    end else begin
      state_q <= state_d;
    end
  end

  // Strobe decode from T-state and opcode; all zero outside StRun.
  always_comb begin
    ctrl = '0;
    if (state_q == StRun) begin
      unique case (1'b1)
        tstate[0]: begin
          ctrl[CtrlEp] = 1'b1;
          ctrl[CtrlLm] = 1'b1;
        end
        tstate[1]: begin
          ctrl[CtrlCp] = 1'b1;
        end
        tstate[2]: begin
          ctrl[CtrlCe] = 1'b1;
          ctrl[CtrlLi] = 1'b1;
        end
        tstate[3]: begin
          if (is_lda || is_arith) begin
            ctrl[CtrlEi] = 1'b1;
            ctrl[CtrlLm] = 1'b1;
          end else if (is_out) begin
            ctrl[CtrlEa] = 1'b1;
            ctrl[CtrlLo] = 1'b1;
          end
        end
        tstate[4]: begin
          if (is_lda) begin
            ctrl[CtrlCe] = 1'b1;
            ctrl[CtrlLa] = 1'b1;
          end else if (is_arith) begin
            ctrl[CtrlCe] = 1'b1;
            ctrl[CtrlLb] = 1'b1;
          end
        end
        tstate[5]: begin
          if (is_arith) begin
            ctrl[CtrlEu] = 1'b1;
            ctrl[CtrlLa] = 1'b1;
            ctrl[CtrlSu] = is_sub;
          end
        end
        default: begin
          ctrl = '0;
        end
      endcase
    end
  end

  assign bus.o_cp     = ctrl[CtrlCp];
  assign bus.o_ep     = ctrl[CtrlEp];
  assign bus.o_lm     = ctrl[CtrlLm];
  assign bus.o_ce     = ctrl[CtrlCe];
  assign bus.o_li     = ctrl[CtrlLi];
  assign bus.o_ei     = ctrl[CtrlEi];
  assign bus.o_la     = ctrl[CtrlLa];
  assign bus.o_ea     = ctrl[CtrlEa];
  assign bus.o_su     = ctrl[CtrlSu];
  assign bus.o_eu     = ctrl[CtrlEu];
  assign bus.o_lb     = ctrl[CtrlLb];
  assign bus.o_lo     = ctrl[CtrlLo];
  assign bus.o_hlt    = (state_q == StHalt);
  assign bus.o_tstate = tstate;

  // The shared bus must never see two drivers at once.
  bus_driver_onehot_a : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    $onehot0({ctrl[CtrlEp], ctrl[CtrlCe], ctrl[CtrlEi], ctrl[CtrlEa], ctrl[CtrlEu]}));

endmodule
